// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch queue: FSM encoding,
// instruction size and the packed {pc,inst} queue entry.
package ifetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    REDIR = 1'b1
  } fetch_state_e;

  localparam int INST_BYTES = 4;
  localparam int IQ_ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-stage bus: ROM address/data, decode valid/ready handshake and redirect.
// master = fetch unit, slave = ROM + decode + redirect source.
interface ifetch_queue_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_addr, inst_valid, inst_out, inst_pc,
    input  imem_data, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, inst_valid, inst_out, inst_pc,
    output imem_data, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifetch_fifo.sv
// DEPTH x 64-bit synchronous prefetch FIFO; head visible one cycle after push.
// Push while full is accepted only alongside a pop; flush empties it and wins over push/pop.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [IQ_ENTRY_W-1:0] wdat_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [IQ_ENTRY_W-1:0] head_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IQ_ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_q;
  logic [PTR_W-1:0]      wr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  do_push;
  logic                  do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: the count gates visibility of every slot.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdat_i;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch PC owner + prefetch queue feeding decode; head valid one cycle after the ROM word is addressed.
// Stalls fetch_pc when the queue is full and not draining; redirect flushes and inserts one bubble. IFETCH_ALIGN_CHECK_EN adds misalign.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic           clk,
  input  logic           reset,
`ifdef IFETCH_ALIGN_CHECK_EN
  output logic           misalign,
`endif
  ifetch_queue_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             push;
  logic             pop;
  logic             hs;
  logic             q_full;
  logic             q_empty;
  logic [CNT_W-1:0] unused_q_count;
  iq_entry_t        wr_ent;
  iq_entry_t        head_ent;

  assign hs             = bus.inst_valid && bus.inst_ready;
  assign wr_ent.pc      = fetch_pc_q;
  assign wr_ent.inst    = bus.imem_data;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = (state_q == FETCH) && !q_empty;
  // Zero the payload when invalid so reset and bubbles present clean outputs.
  assign bus.inst_out   = bus.inst_valid ? head_ent.inst : '0;
  assign bus.inst_pc    = bus.inst_valid ? head_ent.pc   : '0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    pop        = 1'b0;
    if (bus.redirect) begin
      state_d    = REDIR;
      fetch_pc_d = align_pc(bus.redirect_pc);
    end else begin
      unique case (state_q)
        FETCH: begin
          pop  = hs;
          push = !q_full || hs;
          if (push) fetch_pc_d = fetch_pc_q + 32'(INST_BYTES);
        end
        REDIR: state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect),
    .wdat_i  (wr_ent),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (unused_q_count),
    .head_o  (head_ent)
  );

`ifdef IFETCH_ALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign_q <= 1'b0;
    else        misalign_q <= bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (reset && bus.redirect && (bus.redirect_pc[1:0] != 2'b00))
      $display("%0t: misaligned redirect target %h", $time, bus.redirect_pc);
  end

  assign misalign = misalign_q;
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a queue-based reference model checked every cycle.
module tb_ifetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifetch_queue_if bus ();
`ifdef IFETCH_ALIGN_CHECK_EN
  logic misalign;
`endif

  ifetch_queue #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (rst_n),
`ifdef IFETCH_ALIGN_CHECK_EN
    .misalign (misalign),
`endif
    .bus      (bus)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign bus.imem_data = rom(bus.imem_addr);

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] mq[$];
  logic [31:0] mpc;
  bit          mbub;
  bit          mmis;
  logic [31:0] emitted[$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] em(input int i);
    if (i < emitted.size()) return emitted[i];
    return 'x;
  endfunction

  task automatic model_reset();
    mq.delete();
    mpc  = RPC;
    mbub = 1'b0;
    mmis = 1'b0;
  endtask

  // Next-cycle model: flush/bubble on redirect, otherwise pop then push if room.
  task automatic model_step();
    int sz;
    bit popd;
    if (!rst_n) begin
      model_reset();
    end else if (bus.redirect) begin
      mq.delete();
      mpc  = {bus.redirect_pc[31:2], 2'b00};
      mbub = 1'b1;
      mmis = (bus.redirect_pc[1:0] != 2'b00);
    end else begin
      mmis = 1'b0;
      if (mbub) begin
        mbub = 1'b0;
      end else begin
        sz   = mq.size();
        popd = (sz != 0) && bus.inst_ready;
        if (popd) void'(mq.pop_front());
        if (sz < DEPTH || popd) begin
          mq.push_back({mpc, rom(mpc)});
          mpc = mpc + 32'd4;
        end
      end
    end
  endtask

  task automatic check();
    bit ev;
    ev = (mq.size() != 0);
    cmp("inst_valid", 32'(bus.inst_valid), 32'(ev));
    cmp("imem_addr", bus.imem_addr, mpc);
    if (ev && bus.inst_valid) begin
      cmp("inst_pc", bus.inst_pc, mq[0][63:32]);
      cmp("inst_out", bus.inst_out, mq[0][31:0]);
    end
    if (!rst_n) begin
      cmp("rst_inst_pc", bus.inst_pc, 32'h0);
      cmp("rst_inst_out", bus.inst_out, 32'h0);
    end
`ifdef IFETCH_ALIGN_CHECK_EN
    cmp("misalign", 32'(misalign), 32'(mmis));
`endif
  endtask

  task automatic tick();
    if (bus.inst_valid && bus.inst_ready && !bus.redirect) emitted.push_back(bus.inst_pc);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check();
  endtask

  task automatic do_reset(input logic rdy);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst_valid", 32'(bus.inst_valid), 32'h0);
    cmp("async_rst_addr", bus.imem_addr, RPC);
    cmp("async_rst_pc", bus.inst_pc, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n          = 1'b1;
    bus.inst_ready = rdy;
    emitted.delete();
    check();
  endtask

  initial begin
    int stale;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check();
    end

    // Streaming from reset with decode always ready.
    rst_n = 1'b1;
    bus.inst_ready = 1'b1;
    check();
    tick();
    cmp("first_out", bus.inst_out, 32'h1000_0000);
    cmp("first_pc", bus.inst_pc, 32'h0);
    repeat (5) tick();
    cmp("stream_pc1", em(1), 32'h4);
    cmp("stream_pc4", em(4), 32'h10);

    // Fill with decode stalled, then drain while full.
    do_reset(1'b0);
    repeat (10) tick();
    cmp("freeze_addr", bus.imem_addr, 32'h10);
    bus.inst_ready = 1'b1;
    tick();
    cmp("full_pushpop_addr", bus.imem_addr, 32'h14);
    repeat (4) tick();
    for (int i = 0; i < 5; i++) cmp("drain_order", em(i), 32'(i * 4));

    // Redirect with three entries queued.
    do_reset(1'b0);
    repeat (3) tick();
    emitted.delete();
    bus.inst_ready  = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    cmp("redir_bubble", 32'(bus.inst_valid), 32'h0);
    bus.redirect = 1'b0;
    repeat (6) tick();
    cmp("redir_first_pc", em(0), 32'h40);
    stale = 0;
    foreach (emitted[i]) if (emitted[i] < 32'h40) stale++;
    cmp("redir_no_stale", 32'(stale), 32'h0);

    // Back-to-back redirects: only the newer target survives.
    emitted.delete();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h20;
    tick();
    bus.redirect_pc = 32'h60;
    tick();
    bus.redirect = 1'b0;
    repeat (5) tick();
    cmp("b2b_first_pc", em(0), 32'h60);
    cmp("b2b_second_pc", em(1), 32'h64);

    // Reset mid-stream with two entries queued.
    bus.inst_ready = 1'b0;
    tick();
    do_reset(1'b1);
    repeat (3) tick();
    cmp("post_rst_first_pc", em(0), RPC);

    // Misaligned redirect target.
    emitted.delete();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h42;
    tick();
`ifdef IFETCH_ALIGN_CHECK_EN
    cmp("misalign_pulse", 32'(misalign), 32'h1);
`endif
    bus.redirect = 1'b0;
    tick();
`ifdef IFETCH_ALIGN_CHECK_EN
    cmp("misalign_clear", 32'(misalign), 32'h0);
`endif
    repeat (4) tick();
    cmp("misalign_pc", em(0), 32'h40);

    // fetch_pc wraps modulo 2^32.
    emitted.delete();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    tick();
    bus.redirect = 1'b0;
    repeat (7) tick();
    cmp("wrap_pc0", em(0), 32'hFFFF_FFF8);
    cmp("wrap_pc2", em(2), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch stage sitting directly upstream of the instruction ROM and downstream of nothing but the PC redirect logic.
- Owns the fetch PC, drives the ROM word address, captures the combinational ROM output into a small prefetch FIFO, and hands instructions and their PCs to decode over a valid/ready handshake.
- Supports branch/jump redirect with a full queue flush.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- DEPTH, 4: prefetch queue entries; power of two, 2..16.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- imem_addr, output, 32: address to instruction ROM; equals fetch_pc; always word-aligned.
- imem_data, input, 32: ROM read data, valid combinationally in the same cycle as imem_addr.
- inst_valid, output, 1: queue head is valid.
- inst_ready, input, 1: decode accepts the head this cycle.
- inst_out, output, 32: instruction at queue head.
- inst_pc, output, 32: PC of inst_out.
- redirect, input, 1: branch/jump taken this cycle.
- redirect_pc, input, 32: new fetch target; bits [1:0] are ignored and forced to 0.

Behaviour:
- Reset (reset==0, asynchronous): fetch_pc=RESET_PC, queue empty (rd_ptr=wr_ptr=0, count=0), state=FETCH.
  - Outputs during reset: inst_valid=0, inst_out=0, inst_pc=0, imem_addr=RESET_PC.
- State FETCH:
  - Each cycle, push = (count<DEPTH) || (inst_valid && inst_ready).
  - On push: enqueue {imem_data, fetch_pc}; fetch_pc += 4, wrapping modulo 2^32.
- Dequeue: on inst_valid && inst_ready, rd_ptr advances.
  - Simultaneous push and pop when full is legal; count stays at DEPTH.
- Full without pop: fetch_pc holds and imem_addr holds; no enqueue.
- Latency: a word presented at imem_addr in cycle N appears at the head no earlier than cycle N+1.
  - After reset release, inst_valid=1 in the cycle after the first rising edge, with inst_out=ROM[RESET_PC].
- Redirect (in any state):
  - At the edge, queue flushes to empty, fetch_pc <= {redirect_pc[31:2],2'b00}, state <= REDIR.
  - Any enqueue or dequeue in the same cycle is discarded. A handshake that coincides with redirect counts as consumed, but its data is dropped.
- State REDIR:
  - One bubble cycle; inst_valid=0; imem_addr=new fetch_pc; no push.
  - Next state FETCH.
  - A new redirect in REDIR restarts REDIR with the newer target.
- inst_out and inst_pc are don't-care when inst_valid=0; the bench must check them only when valid.
- Reset asserted mid-operation: immediate return to the reset values above; no partial state survives.
- Pointers are log2(DEPTH) bits with natural wrap. count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro: IFETCH_ALIGN_CHECK_EN.
- Defined:
  - Extra output port misalign (1 bit). It pulses high for one cycle after any redirect whose redirect_pc[1:0]!=0.
  - A simulation $display of time and offending address is issued.
  - The target is still forced aligned.
- Undefined: no misalign port; redirect_pc[1:0] is silently dropped.

Decomposition:
- Shared package ifetch_pkg:
  - FSM state encoding: FETCH=1'b0, REDIR=1'b1.
  - Constant INST_BYTES=4.
  - Typedef-style packed entry width IQ_ENTRY_W=64 ({pc,inst}).
- Sub-module ifetch_fifo: parameterized DEPTH x 64-bit synchronous FIFO.
  - Ports: push, pop, flush, full, empty, count, head data.
  - Same asynchronous active-low reset as the parent.
- The top level holds fetch_pc, the FSM and the handshake glue.

Test Plan:
- Reset release, ROM words 0..7 = 32'h1000_0000+i, inst_ready=1 constant -> inst_valid from cycle 1; inst_out = 32'h1000_0000, 32'h1000_0001, ...; inst_pc = 0, 4, 8, ... one per cycle.
- inst_ready=0 for 10 cycles -> queue fills at 4 entries; imem_addr freezes at 32'h10. Then ready=1 -> PCs 0,4,8,C,10 drain in order with no gap or duplicate.
- Queue full, pop and push in the same cycle -> count stays 4; imem_addr advances by 4.
- redirect=1, redirect_pc=32'h40 while 3 entries are queued -> next cycle inst_valid=0 (bubble); following cycle inst_pc=32'h40; no stale PC ever emitted.
- Back-to-back redirects to 32'h20 then 32'h60 -> only PC 32'h60 and its successors appear.
- Assert reset mid-stream with count=2 -> inst_valid=0 immediately (asynchronous). After release, first inst_pc=RESET_PC.
  - With IFETCH_ALIGN_CHECK_EN defined: redirect_pc=32'h42 -> misalign=1 for one cycle and inst_pc=32'h40.
